// File: rtl/loss_batch_ctrl_if.sv
// Handshake and result bundle between the batch controller and its neighbours:
// the training top FSM (start/abort/busy/done/results) and the loss unit
// (forward request, prediction valid, loss enable, registered loss).
// The slave modport is the controller's view; master is the surrounding logic.
interface loss_batch_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int LOSS_W = 46,
    parameter int ACC_W  = 49
);
    logic              start_i;
    logic              abort_i;
    logic              fwd_req_o;
    logic              fwd_valid_i;
    logic              loss_en_o;
    logic [LOSS_W-1:0] loss_i;
    logic [IDX_W-1:0]  sample_idx_o;
    logic              busy_o;
    logic              done_o;
    logic              ovf_o;
    logic [ACC_W-1:0]  batch_loss_o;
    logic [ACC_W-1:0]  batch_mean_o;

    modport slave (
        input  start_i,
        input  abort_i,
        input  fwd_valid_i,
        input  loss_i,
        output fwd_req_o,
        output loss_en_o,
        output sample_idx_o,
        output busy_o,
        output done_o,
        output ovf_o,
        output batch_loss_o,
        output batch_mean_o
    );

    modport master (
        output start_i,
        output abort_i,
        output fwd_valid_i,
        output loss_i,
        input  fwd_req_o,
        input  loss_en_o,
        input  sample_idx_o,
        input  busy_o,
        input  done_o,
        input  ovf_o,
        input  batch_loss_o,
        input  batch_mean_o
    );
endinterface

// File: rtl/loss_batch_ctrl.sv
// Batch sequencer for the squared-error loss unit. Steps through the samples
// of one batch, requests a forward pass for each, enables the loss unit when
// the prediction arrives, and sums the registered per-sample loss into a
// saturating accumulator. Reports the batch sum and the truncated mean.
module loss_batch_ctrl #(
    parameter int BATCH_N = 8,
    parameter int IDX_W   = 3,
    parameter int LOSS_W  = 46,
    parameter int ACC_W   = 49
) (
    input  logic               clk_i,
    input  logic               rst_i,
    loss_batch_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_N - 1);

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] sampleIdx_q, sampleIdx_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic             ovf_q,    ovf_d;
    logic             fwdReq_q, fwdReq_d;

    // One extra bit on the sum exposes the carry that signals saturation.
    logic [ACC_W:0]   accSum;

    // Widened add of the current accumulator and the zero-extended loss.
    always_comb begin
        accSum = {1'b0, acc_q} + {{(ACC_W + 1 - LOSS_W){1'b0}}, bus.loss_i};
    end

    // Next-state logic: abort beats everything, start only counts in IDLE,
    // prediction-valid only counts in REQ.
    always_comb begin
        state_d     = state_q;
        sampleIdx_d = sampleIdx_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        fwdReq_d    = fwdReq_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d     = ST_REQ;
                    sampleIdx_d = '0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    fwdReq_d    = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.abort_i) begin
                    state_d  = ST_IDLE;
                    fwdReq_d = 1'b0;
                end else if (bus.fwd_valid_i) begin
                    state_d  = ST_ACC;
                    fwdReq_d = 1'b0;
                end
            end
            ST_ACC: begin
                if (bus.abort_i) begin
                    state_d  = ST_IDLE;
                    fwdReq_d = 1'b0;
                end else begin
                    if (accSum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = accSum[ACC_W-1:0];
                    end
                    if (sampleIdx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        sampleIdx_d = sampleIdx_q + IDX_W'(1);
                        state_d     = ST_REQ;
                        fwdReq_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                fwdReq_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            sampleIdx_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            fwdReq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampleIdx_q <= sampleIdx_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            fwdReq_q    <= fwdReq_d;
        end
    end

    // Output decode; loss enable is combinational so the loss unit can
    // capture its result on the same edge that moves us into ACC.
    always_comb begin
        bus.fwd_req_o    = fwdReq_q;
        bus.loss_en_o    = (state_q == ST_REQ) & bus.fwd_valid_i & ~bus.abort_i;
        bus.sample_idx_o = sampleIdx_q;
        bus.busy_o       = (state_q != ST_IDLE);
        bus.done_o       = (state_q == ST_DONE);
        bus.ovf_o        = ovf_q;
        bus.batch_loss_o = acc_q;
        bus.batch_mean_o = acc_q >> IDX_W;
    end

endmodule

// File: tb/tb_loss_batch_ctrl.sv
// Bench for loss_batch_ctrl: emulates the loss unit, drives batches with
// random stall patterns and losses, and compares against a sum/mean model.
module tb_loss_batch_ctrl;

    localparam int BATCH_N = 4;
    localparam int IDX_W   = 2;
    localparam int LOSS_W  = 46;
    localparam int ACC_W   = 47;
    localparam longint unsigned ACC_MAX  = (64'd1 << ACC_W) - 64'd1;
    localparam longint unsigned LOSS_MAX = (64'd1 << LOSS_W) - 64'd1;

    logic clk = 1'b0;
    logic rst_n;
    int checkCount = 0;
    int passCount  = 0;
    int enCount    = 0;
    int doneCount  = 0;
    longint unsigned lossTable [BATCH_N];

    always #5 clk = ~clk;

    loss_batch_ctrl_if #(.IDX_W(IDX_W), .LOSS_W(LOSS_W), .ACC_W(ACC_W)) bus ();

    loss_batch_ctrl #(
        .BATCH_N(BATCH_N), .IDX_W(IDX_W), .LOSS_W(LOSS_W), .ACC_W(ACC_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus.slave)
    );

    // Loss unit stand-in: registers the loss of the enabled sample and counts
    // enable and done pulses.
    always @(posedge clk) begin
        if (bus.loss_en_o) begin
            bus.loss_i <= lossTable[bus.sample_idx_o][LOSS_W-1:0];
            enCount    <= enCount + 1;
        end
        if (bus.done_o) doneCount <= doneCount + 1;
    end

    function automatic longint unsigned rawSum();
        longint unsigned s = 0;
        for (int i = 0; i < BATCH_N; i++) s += lossTable[i];
        return s;
    endfunction

    function automatic longint unsigned modelSum();
        return (rawSum() > ACC_MAX) ? ACC_MAX : rawSum();
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic driveBatch(input int delays [BATCH_N], input bit inject,
                              output bit heldOk, output bit timedOut);
        int n;
        heldOk = 1'b1;
        timedOut = 1'b0;
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        for (int s = 0; s < BATCH_N; s++) begin
            n = 0;
            while (bus.fwd_req_o !== 1'b1 && n < 50) begin tick(); n++; end
            if (n >= 50) begin timedOut = 1'b1; return; end
            if (inject) begin
                bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
                if (bus.fwd_req_o !== 1'b1 || bus.sample_idx_o !== IDX_W'(s)) heldOk = 1'b0;
            end
            for (int d = 0; d < delays[s]; d++) begin
                tick();
                if (bus.fwd_req_o !== 1'b1 || bus.sample_idx_o !== IDX_W'(s) || bus.loss_en_o !== 1'b0) heldOk = 1'b0;
            end
            bus.fwd_valid_i = 1'b1; #1;
            if (bus.loss_en_o !== 1'b1) heldOk = 1'b0;
            tick(); bus.fwd_valid_i = 1'b0;
            if (inject) begin
                bus.start_i = 1'b1; bus.fwd_valid_i = 1'b1; #1;
                if (bus.loss_en_o !== 1'b0) heldOk = 1'b0;
                tick(); bus.start_i = 1'b0; bus.fwd_valid_i = 1'b0;
            end
        end
        n = 0;
        while (bus.done_o !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin timedOut = 1'b1; return; end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.fwd_valid_i = 1'b0;
        repeat (2) tick();
        checkCount++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.fwd_req_o !== 1'b0) $display("[TB] FAIL reset_ctrl: busy=%b done=%b req=%b expected 000", bus.busy_o, bus.done_o, bus.fwd_req_o); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd0 || bus.sample_idx_o !== '0 || bus.ovf_o !== 1'b0) $display("[TB] FAIL reset_data: loss=%0d idx=%0d ovf=%b expected 0", bus.batch_loss_o, bus.sample_idx_o, bus.ovf_o); else passCount++;
        rst_n = 1'b1; tick();
    endtask

    task automatic test_basic();
        int dl [BATCH_N];
        int enSnap, doneSnap;
        bit held, tout;
        lossTable = '{9, 16, 0, 25};
        dl = '{1, 1, 1, 1};
        enSnap = enCount; doneSnap = doneCount;
        driveBatch(dl, 1'b0, held, tout);
        checkCount++; if (tout) $display("[TB] FAIL basic_timeout: batch did not complete, expected done"); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd50) $display("[TB] FAIL basic_sum: got %0d expected 50", bus.batch_loss_o); else passCount++;
        checkCount++; if (64'(bus.batch_mean_o) !== 64'd12) $display("[TB] FAIL basic_mean: got %0d expected 12", bus.batch_mean_o); else passCount++;
        checkCount++; if (enCount - enSnap != BATCH_N) $display("[TB] FAIL basic_en_pulses: got %0d expected %0d", enCount - enSnap, BATCH_N); else passCount++;
        checkCount++; if (doneCount - doneSnap != 1) $display("[TB] FAIL basic_done_pulse: got %0d cycles expected 1", doneCount - doneSnap); else passCount++;
        checkCount++; if (bus.busy_o !== 1'b0 || held !== 1'b1) $display("[TB] FAIL basic_idle: busy=%b held=%b expected 0/1", bus.busy_o, held); else passCount++;
    endtask

    task automatic test_stall();
        int dl [BATCH_N];
        int enSnap;
        bit held, tout;
        lossTable = '{9, 16, 0, 25};
        dl = '{1, 1, 5, 1};
        enSnap = enCount;
        driveBatch(dl, 1'b0, held, tout);
        checkCount++; if (tout || held !== 1'b1) $display("[TB] FAIL stall_hold: timeout=%b held=%b expected 0/1", tout, held); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd50) $display("[TB] FAIL stall_sum: got %0d expected 50", bus.batch_loss_o); else passCount++;
        checkCount++; if (enCount - enSnap != BATCH_N) $display("[TB] FAIL stall_en_pulses: got %0d expected %0d", enCount - enSnap, BATCH_N); else passCount++;
    endtask

    task automatic test_saturation();
        int dl [BATCH_N];
        bit held, tout;
        for (int i = 0; i < BATCH_N; i++) begin lossTable[i] = LOSS_MAX; dl[i] = $urandom_range(0, 2); end
        driveBatch(dl, 1'b0, held, tout);
        checkCount++; if (tout || 64'(bus.batch_loss_o) !== ACC_MAX) $display("[TB] FAIL sat_sum: got %0d expected %0d", bus.batch_loss_o, ACC_MAX); else passCount++;
        checkCount++; if (bus.ovf_o !== 1'b1) $display("[TB] FAIL sat_ovf: got %b expected 1", bus.ovf_o); else passCount++;
        checkCount++; if (64'(bus.batch_mean_o) !== (ACC_MAX >> IDX_W)) $display("[TB] FAIL sat_mean: got %0d expected %0d", bus.batch_mean_o, ACC_MAX >> IDX_W); else passCount++;
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd0 || bus.ovf_o !== 1'b0) $display("[TB] FAIL sat_restart: loss=%0d ovf=%b expected 0/0", bus.batch_loss_o, bus.ovf_o); else passCount++;
        bus.abort_i = 1'b1; tick(); bus.abort_i = 1'b0;
    endtask

    task automatic test_abort();
        int enSnap, doneSnap;
        for (int i = 0; i < BATCH_N; i++) lossTable[i] = 64'(100 + $urandom_range(0, 1000));
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        bus.fwd_valid_i = 1'b1; tick(); bus.fwd_valid_i = 1'b0;
        tick();
        enSnap = enCount; doneSnap = doneCount;
        bus.fwd_valid_i = 1'b1; bus.abort_i = 1'b1; #1;
        checkCount++; if (bus.loss_en_o !== 1'b0) $display("[TB] FAIL abort_en: got %b expected 0", bus.loss_en_o); else passCount++;
        tick(); bus.fwd_valid_i = 1'b0; bus.abort_i = 1'b0;
        repeat (3) tick();
        checkCount++; if (bus.busy_o !== 1'b0 || bus.fwd_req_o !== 1'b0) $display("[TB] FAIL abort_idle: busy=%b req=%b expected 0/0", bus.busy_o, bus.fwd_req_o); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== lossTable[0]) $display("[TB] FAIL abort_partial: got %0d expected %0d", bus.batch_loss_o, lossTable[0]); else passCount++;
        checkCount++; if (doneCount != doneSnap || enCount != enSnap) $display("[TB] FAIL abort_pulses: done=%0d en=%0d expected 0/0", doneCount - doneSnap, enCount - enSnap); else passCount++;
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        checkCount++; if (bus.sample_idx_o !== '0 || 64'(bus.batch_loss_o) !== 64'd0 || bus.busy_o !== 1'b1) $display("[TB] FAIL abort_restart: idx=%0d loss=%0d busy=%b expected 0/0/1", bus.sample_idx_o, bus.batch_loss_o, bus.busy_o); else passCount++;
        bus.abort_i = 1'b1; tick(); bus.abort_i = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        int dl [BATCH_N];
        int enSnap;
        longint unsigned lossSnap;
        bit held, tout;
        for (int i = 0; i < BATCH_N; i++) begin lossTable[i] = 64'($urandom_range(1, 5000)); dl[i] = $urandom_range(0, 2); end
        enSnap = enCount;
        driveBatch(dl, 1'b1, held, tout);
        checkCount++; if (tout || held !== 1'b1) $display("[TB] FAIL ignore_busy_hold: timeout=%b held=%b expected 0/1", tout, held); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== modelSum() || enCount - enSnap != BATCH_N) $display("[TB] FAIL ignore_busy_sum: got %0d/%0d expected %0d/%0d", bus.batch_loss_o, enCount - enSnap, modelSum(), BATCH_N); else passCount++;
        lossSnap = 64'(bus.batch_loss_o);
        enSnap = enCount;
        bus.fwd_valid_i = 1'b1; tick(); tick(); bus.fwd_valid_i = 1'b0;
        bus.start_i = 1'b1; bus.abort_i = 1'b1; tick(); bus.start_i = 1'b0; bus.abort_i = 1'b0;
        tick();
        checkCount++; if (bus.busy_o !== 1'b0 || 64'(bus.batch_loss_o) !== lossSnap || enCount != enSnap) $display("[TB] FAIL ignore_idle: busy=%b loss=%0d en=%0d expected 0/%0d/0", bus.busy_o, bus.batch_loss_o, enCount - enSnap, lossSnap); else passCount++;
    endtask

    task automatic test_async_reset();
        int dl [BATCH_N];
        bit held, tout;
        lossTable = '{9, 16, 0, 25};
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        bus.fwd_valid_i = 1'b1; tick(); bus.fwd_valid_i = 1'b0;
        tick();
        bus.fwd_valid_i = 1'b1; tick(); bus.fwd_valid_i = 1'b0;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd9 || bus.busy_o !== 1'b1) $display("[TB] FAIL areset_pre: loss=%0d busy=%b expected 9/1", bus.batch_loss_o, bus.busy_o); else passCount++;
        #2 rst_n = 1'b0;
        #1;
        checkCount++; if (bus.busy_o !== 1'b0 || bus.fwd_req_o !== 1'b0 || bus.done_o !== 1'b0 || bus.loss_en_o !== 1'b0 || bus.ovf_o !== 1'b0) $display("[TB] FAIL areset_ctrl: busy=%b req=%b done=%b en=%b ovf=%b expected 0", bus.busy_o, bus.fwd_req_o, bus.done_o, bus.loss_en_o, bus.ovf_o); else passCount++;
        checkCount++; if (64'(bus.batch_loss_o) !== 64'd0 || 64'(bus.batch_mean_o) !== 64'd0 || bus.sample_idx_o !== '0) $display("[TB] FAIL areset_data: loss=%0d mean=%0d idx=%0d expected 0", bus.batch_loss_o, bus.batch_mean_o, bus.sample_idx_o); else passCount++;
        tick(); rst_n = 1'b1; tick();
        dl = '{1, 1, 1, 1};
        driveBatch(dl, 1'b0, held, tout);
        checkCount++; if (tout || 64'(bus.batch_loss_o) !== 64'd50 || 64'(bus.batch_mean_o) !== 64'd12) $display("[TB] FAIL areset_rerun: got %0d/%0d expected 50/12", bus.batch_loss_o, bus.batch_mean_o); else passCount++;
    endtask

    task automatic test_random_batches();
        int dl [BATCH_N];
        int enSnap, doneSnap;
        bit held, tout;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < BATCH_N; i++) begin
                if ($urandom_range(0, 1) == 0) lossTable[i] = 64'($urandom_range(0, 1 << 20));
                else lossTable[i] = {$urandom, $urandom} & LOSS_MAX;
                dl[i] = $urandom_range(0, 3);
            end
            enSnap = enCount; doneSnap = doneCount;
            driveBatch(dl, 1'b0, held, tout);
            checkCount++; if (tout || 64'(bus.batch_loss_o) !== modelSum()) $display("[TB] FAIL rand_sum[%0d]: got %0d expected %0d", it, bus.batch_loss_o, modelSum()); else passCount++;
            checkCount++; if (64'(bus.batch_mean_o) !== (modelSum() >> IDX_W)) $display("[TB] FAIL rand_mean[%0d]: got %0d expected %0d", it, bus.batch_mean_o, modelSum() >> IDX_W); else passCount++;
            checkCount++; if (bus.ovf_o !== (rawSum() > ACC_MAX)) $display("[TB] FAIL rand_ovf[%0d]: got %b expected %b", it, bus.ovf_o, rawSum() > ACC_MAX); else passCount++;
            checkCount++; if (enCount - enSnap != BATCH_N || doneCount - doneSnap != 1) $display("[TB] FAIL rand_pulses[%0d]: en=%0d done=%0d expected %0d/1", it, enCount - enSnap, doneCount - doneSnap, BATCH_N); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_abort();
        test_ignored_inputs();
        test_async_reset();
        test_random_batches();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
